sigplayback: RTL

- Record/playback engine for the audio path.
- Captures a burst of microphone samples into an internal buffer, then replays the burst to the speaker, once or looped, on command.
- The write side advances on the shared sample strobe `en`; the read side drains what the write side captured.
- Sits between the ADC sample register and the speaker DAC, beside the delay-line path.

---
 rtl/sigplayback.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sigplayback.sv
`default_nettype none
// ============================================================================
//  Module      : sigplayback
//  Description : Record/playback engine. Captures a burst of microphone
//                samples into an internal buffer on the sample strobe, then
//                replays it to the speaker once or looped.
//  Revision    : 1.0 - initial release
// ============================================================================
module sigplayback #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  rec,
    input  logic                  play,
    input  logic                  stop,
    input  logic                  loop,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic [DATA_WIDTH-1:0] microphone,
    output logic [DATA_WIDTH-1:0] speaker,
    output logic                  busy,
    output logic                  playing,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_rec  = 2'd1;
    localparam logic [1:0] c_st_play = 2'd2;

    localparam int                  c_depth    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_full_len = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_one      = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];

    logic [1:0]            r_state;
    logic [ADDR_WIDTH:0]   r_addr;
    logic [ADDR_WIDTH:0]   r_captured;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_speaker;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_playing;

    logic [1:0]            w_state_nx;
    logic [ADDR_WIDTH:0]   w_addr_nx;
    logic [ADDR_WIDTH:0]   w_captured_nx;
    logic [ADDR_WIDTH:0]   w_len_nx;
    logic [ADDR_WIDTH:0]   w_count_nx;
    logic                  w_done_nx;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_silence;
    logic [ADDR_WIDTH:0]   w_addr_inc;
    logic [ADDR_WIDTH:0]   w_cap_inc;
    logic [ADDR_WIDTH-1:0] w_index;

    assign w_addr_inc = r_addr + c_one;
    assign w_cap_inc  = r_captured + c_one;
    assign w_index    = r_addr[ADDR_WIDTH-1:0];

    always_comb begin
        w_state_nx    = r_state;
        w_addr_nx     = r_addr;
        w_captured_nx = r_captured;
        w_len_nx      = r_len;
        w_count_nx    = r_count;
        w_done_nx     = 1'b0;
        w_wr          = 1'b0;
        w_rd          = 1'b0;
        w_silence     = 1'b0;

        case (r_state)
            c_st_idle: begin
                w_silence = en;
                if (rec) begin
                    w_state_nx    = c_st_rec;
                    w_len_nx      = (length == '0) ? c_full_len : {1'b0, length};
                    w_addr_nx     = '0;
                    w_captured_nx = '0;
                end else if (play) begin
                    w_state_nx = c_st_play;
                    w_addr_nx  = '0;
                end
            end

            c_st_rec: begin
                w_silence = en;
                if (stop) begin
                    // Abort keeps whatever was captured so far as the valid burst
                    w_state_nx = c_st_idle;
                    w_count_nx = r_captured;
                    w_done_nx  = 1'b1;
                end else if (en) begin
                    w_wr          = 1'b1;
                    w_addr_nx     = w_addr_inc;
                    w_captured_nx = w_cap_inc;
                    if (w_cap_inc == r_len) begin
                        w_state_nx = c_st_idle;
                        w_count_nx = r_len;
                        w_done_nx  = 1'b1;
                    end
                end
            end

            c_st_play: begin
                if (stop || (r_count == '0)) begin
                    w_state_nx = c_st_idle;
                    w_done_nx  = 1'b1;
                end else if (en) begin
                    w_rd      = 1'b1;
                    w_addr_nx = w_addr_inc;
                    if (w_addr_inc == r_count) begin
                        if (loop) begin
                            w_addr_nx = '0;
                        end else begin
                            w_state_nx = c_st_idle;
                            w_done_nx  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                w_state_nx = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_addr     <= '0;
            r_captured <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_playing  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_addr     <= w_addr_nx;
            r_captured <= w_captured_nx;
            r_len      <= w_len_nx;
            r_count    <= w_count_nx;
            r_done     <= w_done_nx;
            r_busy     <= (w_state_nx != c_st_idle);
            r_playing  <= (w_state_nx == c_st_play);
        end
    end

    // Buffer contents survive reset; only the write enable is gated by it
    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            r_mem[w_index] <= microphone;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_speaker <= '0;
        end else if (w_rd) begin
            r_speaker <= r_mem[w_index];
        end else if (w_silence) begin
            r_speaker <= '0;
        end
    end

    assign speaker = r_speaker;
    assign busy    = r_busy;
    assign playing = r_playing;
    assign done    = r_done;
    assign count   = r_count;

endmodule
`default_nettype wire
